// File: rtl/msdap_pkg.sv
`default_nettype none
// ============================================================================
//  msdap_pkg
//  Shared types and constants for the MSDAP sequencing controller: state
//  encoding, memory depths, address and counter widths, sleep threshold.
//  Revision: 1.0  initial release
// ============================================================================
package msdap_pkg;

    localparam int WORD_W     = 16;
    localparam int RJ_DEPTH   = 16;
    localparam int COEF_DEPTH = 512;
    localparam int X_DEPTH    = 256;
    localparam int ZERO_LIMIT = 800;

    localparam int RJ_AW   = 4;
    localparam int COEF_AW = 9;
    localparam int X_AW    = 8;
    localparam int LOAD_CW = 9;   // one counter serves Rj, coefficient and sweep phases
    localparam int ZCNT_W  = 10;

    // Sweep finishes when the counter has passed the last X address.
    localparam logic [LOAD_CW-1:0] SWEEP_LEN = LOAD_CW'(X_DEPTH);
    localparam logic [LOAD_CW-1:0] RJ_LAST   = LOAD_CW'(RJ_DEPTH - 1);
    localparam logic [LOAD_CW-1:0] COEF_LAST = LOAD_CW'(COEF_DEPTH - 1);
    // n parks at the last index so the first sample after a load or clear lands at 0.
    localparam logic [X_AW-1:0]    N_PARK    = X_AW'(X_DEPTH - 1);

    typedef enum logic [3:0] {
        ST_INIT      = 4'd0,
        ST_READ_RJ   = 4'd1,
        ST_READ_COEF = 4'd2,
        ST_WORKING   = 4'd3,
        ST_CLEAR     = 4'd4,
        ST_SLEEP     = 4'd5
    } state_e;

endpackage
`default_nettype wire

// File: rtl/msdap_zero_det.sv
`default_nettype none
// ============================================================================
//  msdap_zero_det
//  Consecutive-zero sample counter. Counts accepted zero samples, clears on
//  any nonzero sample, saturates at ZERO_LIMIT. hit_o flags the accepted
//  sample that brings the run up to ZERO_LIMIT (combinational, so the
//  controller can change state on that same edge).
//
//  Ports
//    clk_i   in   clock
//    rst_i   in   asynchronous active-high reset
//    clr_i   in   synchronous clear (restart / clear-memory entry)
//    step_i  in   a sample is being accepted this cycle
//    zero_i  in   the sample being accepted is zero
//    hit_o   out  this sample is the ZERO_LIMIT-th consecutive zero
//  Revision: 1.0  initial release
// ============================================================================
module msdap_zero_det
    import msdap_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic step_i,
    input  logic zero_i,
    output logic hit_o
);

    localparam logic [ZCNT_W-1:0] LIMIT = ZCNT_W'(ZERO_LIMIT);

    logic [ZCNT_W-1:0] cnt_q;
    logic [ZCNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (step_i) begin
            if (!zero_i) begin
                cnt_d = '0;
            end else if (cnt_q != LIMIT) begin
                // Saturate so a long zero run in sleep never re-fires hit_o.
                cnt_d = cnt_q + ZCNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign hit_o = step_i && zero_i && (cnt_q == (LIMIT - ZCNT_W'(1)));

endmodule
`default_nettype wire

// File: rtl/msdap_ctrl.sv
`default_nettype none
// ============================================================================
//  msdap_ctrl
//  Sequencing controller for the MSDAP filter datapath. Clears the sample
//  memory, loads 16 Rj words and 512 coefficients, then streams samples into
//  a circular X memory, pulsing the ALU once per sample. Enters sleep after a
//  long zero run and wakes on the first nonzero sample. All outputs are
//  registered.
//
//  Ports
//    Sclk        in   system clock, rising edge
//    Reset       in   asynchronous active-high reset
//    Start       in   level; holds the controller in INIT
//    clear_req   in   request to re-clear X (WORKING / SLEEP only)
//    in_word     in   deserialized 16-bit word
//    word_valid  in   one-cycle strobe qualifying in_word
//    alu_done    in   one-cycle pulse, ALU result ready
//    InReady     out  controller accepts words
//    rj_we/rj_waddr, coef_we/coef_waddr, x_we/x_waddr   out  memory writes
//    wdata       out  shared write data
//    n           out  index of most recently written sample
//    alu_en      out  one-cycle ALU start, coincident with x_we
//    sleep       out  high while sleeping
//    overrun     out  sticky: sample arrived while ALU busy
//    state       out  state encoding (debug)
//  Revision: 1.0  initial release
// ============================================================================
module msdap_ctrl
    import msdap_pkg::*;
(
    input  logic               Sclk,
    input  logic               Reset,
    input  logic               Start,
    input  logic               clear_req,
    input  logic [WORD_W-1:0]  in_word,
    input  logic               word_valid,
    input  logic               alu_done,
    output logic               InReady,
    output logic               rj_we,
    output logic [RJ_AW-1:0]   rj_waddr,
    output logic               coef_we,
    output logic [COEF_AW-1:0] coef_waddr,
    output logic               x_we,
    output logic [X_AW-1:0]    x_waddr,
    output logic [WORD_W-1:0]  wdata,
    output logic [X_AW-1:0]    n,
    output logic               alu_en,
    output logic               sleep,
    output logic               overrun,
    output logic [3:0]         state
);

    state_e              state_q;
    logic [LOAD_CW-1:0]  cnt_q;
    logic [X_AW-1:0]     n_q;
    logic                busy_q;
    logic                in_ready_q;
    logic                rj_we_q;
    logic [RJ_AW-1:0]    rj_waddr_q;
    logic                coef_we_q;
    logic [COEF_AW-1:0]  coef_waddr_q;
    logic                x_we_q;
    logic [X_AW-1:0]     x_waddr_q;
    logic [WORD_W-1:0]   wdata_q;
    logic                alu_en_q;
    logic                sleep_q;
    logic                overrun_q;

    logic                stream_st;
    logic                clear_entry;
    logic                accept_sample;
    logic                zero_hit;
    logic                busy_eff;
    logic [X_AW-1:0]     n_inc;

    assign stream_st     = (state_q == ST_WORKING) || (state_q == ST_SLEEP);
    // clear_req outranks word_valid: a word arriving with the request is dropped.
    assign clear_entry   = !Start && stream_st && clear_req;
    assign accept_sample = !Start && stream_st && !clear_req && word_valid;
    assign n_inc         = n_q + X_AW'(1);
    // A done pulse in the same cycle as a new sample means the ALU is free.
    assign busy_eff      = busy_q && !alu_done;

    msdap_zero_det u_zero_det (
        .clk_i  (Sclk),
        .rst_i  (Reset),
        .clr_i  (Start || clear_entry),
        .step_i (accept_sample),
        .zero_i (in_word == '0),
        .hit_o  (zero_hit)
    );

    always_ff @(posedge Sclk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            n_q          <= N_PARK;
            busy_q       <= 1'b0;
            in_ready_q   <= 1'b0;
            rj_we_q      <= 1'b0;
            rj_waddr_q   <= '0;
            coef_we_q    <= 1'b0;
            coef_waddr_q <= '0;
            x_we_q       <= 1'b0;
            x_waddr_q    <= '0;
            wdata_q      <= '0;
            alu_en_q     <= 1'b0;
            sleep_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            rj_we_q   <= 1'b0;
            coef_we_q <= 1'b0;
            x_we_q    <= 1'b0;
            alu_en_q  <= 1'b0;
            if (alu_done) begin
                busy_q <= 1'b0;
            end

            if (Start) begin
                state_q    <= ST_INIT;
                cnt_q      <= '0;
                n_q        <= N_PARK;
                busy_q     <= 1'b0;
                in_ready_q <= 1'b0;
                sleep_q    <= 1'b0;
                overrun_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_INIT, ST_CLEAR: begin
                        if (cnt_q == SWEEP_LEN) begin
                            cnt_q      <= '0;
                            in_ready_q <= 1'b1;
                            state_q    <= (state_q == ST_INIT) ? ST_READ_RJ : ST_WORKING;
                        end else begin
                            x_we_q    <= 1'b1;
                            x_waddr_q <= cnt_q[X_AW-1:0];
                            wdata_q   <= '0;
                            cnt_q     <= cnt_q + LOAD_CW'(1);
                        end
                    end

                    ST_READ_RJ: begin
                        if (word_valid) begin
                            rj_we_q    <= 1'b1;
                            rj_waddr_q <= cnt_q[RJ_AW-1:0];
                            wdata_q    <= in_word;
                            if (cnt_q == RJ_LAST) begin
                                cnt_q   <= '0;
                                state_q <= ST_READ_COEF;
                            end else begin
                                cnt_q <= cnt_q + LOAD_CW'(1);
                            end
                        end
                    end

                    ST_READ_COEF: begin
                        if (word_valid) begin
                            coef_we_q    <= 1'b1;
                            coef_waddr_q <= cnt_q[COEF_AW-1:0];
                            wdata_q      <= in_word;
                            if (cnt_q == COEF_LAST) begin
                                cnt_q   <= '0;
                                n_q     <= N_PARK;
                                state_q <= ST_WORKING;
                            end else begin
                                cnt_q <= cnt_q + LOAD_CW'(1);
                            end
                        end
                    end

                    ST_WORKING, ST_SLEEP: begin
                        if (clear_entry) begin
                            // First sweep write is issued on entry so the
                            // sweep occupies exactly X_DEPTH cycles.
                            state_q    <= ST_CLEAR;
                            in_ready_q <= 1'b0;
                            overrun_q  <= 1'b0;
                            sleep_q    <= 1'b0;
                            n_q        <= N_PARK;
                            x_we_q     <= 1'b1;
                            x_waddr_q  <= '0;
                            wdata_q    <= '0;
                            cnt_q      <= LOAD_CW'(1);
                        end else if (accept_sample) begin
                            n_q       <= n_inc;
                            x_we_q    <= 1'b1;
                            x_waddr_q <= n_inc;
                            wdata_q   <= in_word;
                            if (state_q == ST_WORKING) begin
                                alu_en_q <= 1'b1;
                                busy_q   <= 1'b1;
                                if (busy_eff) begin
                                    overrun_q <= 1'b1;
                                end
                                if (zero_hit) begin
                                    state_q <= ST_SLEEP;
                                    sleep_q <= 1'b1;
                                end
                            end else if (in_word != '0) begin
                                alu_en_q <= 1'b1;
                                busy_q   <= 1'b1;
                                sleep_q  <= 1'b0;
                                state_q  <= ST_WORKING;
                            end
                        end
                    end

                    default: begin
                        state_q <= ST_INIT;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign InReady    = in_ready_q;
    assign rj_we      = rj_we_q;
    assign rj_waddr   = rj_waddr_q;
    assign coef_we    = coef_we_q;
    assign coef_waddr = coef_waddr_q;
    assign x_we       = x_we_q;
    assign x_waddr    = x_waddr_q;
    assign wdata      = wdata_q;
    assign n          = n_q;
    assign alu_en     = alu_en_q;
    assign sleep      = sleep_q;
    assign overrun    = overrun_q;
    assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_msdap_ctrl.sv
`default_nettype none
// ============================================================================
//  tb_msdap_ctrl
//  Self-checking bench for msdap_ctrl. Randomized words and gaps; expected
//  behaviour comes from a sample-level model (index, zero-run length, sleep,
//  ALU busy, overrun) kept in plain variables.
//  Revision: 1.0  initial release
// ============================================================================
module tb_msdap_ctrl;

    localparam int MODEL_ZERO_LIMIT = 800;
    localparam int MODEL_X_DEPTH    = 256;

    logic        Sclk;
    logic        Reset;
    logic        Start;
    logic        clear_req;
    logic [15:0] in_word;
    logic        word_valid;
    logic        alu_done;
    logic        InReady;
    logic        rj_we;
    logic [3:0]  rj_waddr;
    logic        coef_we;
    logic [8:0]  coef_waddr;
    logic        x_we;
    logic [7:0]  x_waddr;
    logic [15:0] wdata;
    logic [7:0]  n;
    logic        alu_en;
    logic        sleep;
    logic        overrun;
    logic [3:0]  state;

    msdap_ctrl dut (
        .Sclk       (Sclk),
        .Reset      (Reset),
        .Start      (Start),
        .clear_req  (clear_req),
        .in_word    (in_word),
        .word_valid (word_valid),
        .alu_done   (alu_done),
        .InReady    (InReady),
        .rj_we      (rj_we),
        .rj_waddr   (rj_waddr),
        .coef_we    (coef_we),
        .coef_waddr (coef_waddr),
        .x_we       (x_we),
        .x_waddr    (x_waddr),
        .wdata      (wdata),
        .n          (n),
        .alu_en     (alu_en),
        .sleep      (sleep),
        .overrun    (overrun),
        .state      (state)
    );

    initial begin
        Sclk = 1'b0;
        forever #5 Sclk = ~Sclk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // Write-event tallies
    int rj_cnt     = 0;
    int coef_cnt   = 0;
    int x_cnt      = 0;
    int alu_cnt    = 0;
    int alu_orphan = 0;

    always @(negedge Sclk) begin
        if (rj_we)            rj_cnt++;
        if (coef_we)          coef_cnt++;
        if (x_we)             x_cnt++;
        if (alu_en)           alu_cnt++;
        if (alu_en && !x_we)  alu_orphan++;
    end

    // Sample-level reference model
    int m_n;
    int m_zeros;
    bit m_sleep;
    bit m_busy;
    bit m_overrun;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Sclk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    function automatic logic [15:0] rand_sample();
        if ($urandom_range(0, 7) == 0) return 16'h0000;
        return 16'($urandom);
    endfunction

    task automatic check_reset_vals(input string pfx);
        check_val({pfx, "_state"},      32'(state),      32'd0);
        check_val({pfx, "_inready"},    32'(InReady),    32'd0);
        check_val({pfx, "_rj_we"},      32'(rj_we),      32'd0);
        check_val({pfx, "_coef_we"},    32'(coef_we),    32'd0);
        check_val({pfx, "_x_we"},       32'(x_we),       32'd0);
        check_val({pfx, "_rj_waddr"},   32'(rj_waddr),   32'd0);
        check_val({pfx, "_coef_waddr"}, 32'(coef_waddr), 32'd0);
        check_val({pfx, "_x_waddr"},    32'(x_waddr),    32'd0);
        check_val({pfx, "_wdata"},      32'(wdata),      32'd0);
        check_val({pfx, "_n"},          32'(n),          32'd255);
        check_val({pfx, "_alu_en"},     32'(alu_en),     32'd0);
        check_val({pfx, "_sleep"},      32'(sleep),      32'd0);
        check_val({pfx, "_overrun"},    32'(overrun),    32'd0);
    endtask

    task automatic load_word(input logic [15:0] w, input bit is_rj, input int idx);
        idle($urandom_range(0, 2));
        in_word    = w;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        if (is_rj) begin
            check_val("rj_we",    32'(rj_we),    32'd1);
            check_val("rj_waddr", 32'(rj_waddr), 32'(idx));
        end else begin
            check_val("coef_we",    32'(coef_we),    32'd1);
            check_val("coef_waddr", 32'(coef_waddr), 32'(idx));
        end
        check_val("load_wdata", 32'(wdata), 32'(w));
        check_val("load_x_we",  32'(x_we),  32'd0);
    endtask

    task automatic send_sample(input logic [15:0] w, input bit do_done);
        bit exp_alu;
        idle($urandom_range(0, 2));
        in_word    = w;
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;

        m_n = (m_n + 1) % MODEL_X_DEPTH;
        if (m_sleep) begin
            exp_alu = (w != 16'h0);
            if (exp_alu) begin
                m_sleep = 1'b0;
                m_zeros = 0;
            end
        end else begin
            exp_alu = 1'b1;
            if (m_busy) m_overrun = 1'b1;
            m_zeros = (w == 16'h0) ? m_zeros + 1 : 0;
            if (m_zeros == MODEL_ZERO_LIMIT) m_sleep = 1'b1;
        end
        if (exp_alu) m_busy = 1'b1;

        check_val("s_x_we",    32'(x_we),    32'd1);
        check_val("s_x_waddr", 32'(x_waddr), 32'(m_n));
        check_val("s_wdata",   32'(wdata),   32'(w));
        check_val("s_n",       32'(n),       32'(m_n));
        check_val("s_alu_en",  32'(alu_en),  32'(exp_alu));
        check_val("s_sleep",   32'(sleep),   32'(m_sleep));
        check_val("s_overrun", 32'(overrun), 32'(m_overrun));
        check_val("s_state",   32'(state),   m_sleep ? 32'd5 : 32'd3);
        check_val("s_rj_we",   32'(rj_we),   32'd0);
        check_val("s_coef_we", 32'(coef_we), 32'd0);

        if (do_done && m_busy) begin
            alu_done = 1'b1;
            tick();
            alu_done = 1'b0;
            m_busy   = 1'b0;
        end
    endtask

    initial begin
        int x0;
        int a0;
        Reset      = 1'b0;
        Start      = 1'b1;
        clear_req  = 1'b0;
        in_word    = 16'h0;
        word_valid = 1'b0;
        alu_done   = 1'b0;

        // Asynchronous reset: values appear without a clock edge
        #2 Reset = 1'b1;
        #1;
        check_reset_vals("rst");
        idle(3);
        Reset = 1'b0;

        // Start held high keeps INIT idle
        idle(300);
        check_val("start_state",   32'(state),   32'd0);
        check_val("start_x_we",    32'(x_we),    32'd0);
        check_val("start_inready", 32'(InReady), 32'd0);
        Start = 1'b0;

        // INIT sweep: 256 zero writes at ascending addresses
        x0 = x_cnt;
        for (int k = 0; k < 256; k++) begin
            tick();
            check_val("init_x_we",    32'(x_we),    32'd1);
            check_val("init_x_waddr", 32'(x_waddr), 32'(k));
            check_val("init_wdata",   32'(wdata),   32'd0);
            check_val("init_inready", 32'(InReady), 32'd0);
        end
        tick();
        check_val("init_done_inready", 32'(InReady), 32'd1);
        check_val("init_done_state",   32'(state),   32'd1);
        check_val("init_done_x_we",    32'(x_we),    32'd0);
        check_val("init_x_count",      32'(x_cnt - x0), 32'd256);

        for (int i = 0; i < 16; i++) load_word(16'($urandom), 1'b1, i);
        check_val("rj_done_state", 32'(state), 32'd2);
        for (int i = 0; i < 512; i++) load_word(16'($urandom), 1'b0, i);
        check_val("coef_done_state", 32'(state),   32'd3);
        check_val("coef_done_n",     32'(n),       32'd255);
        check_val("coef_done_rdy",   32'(InReady), 32'd1);
        idle(1);
        check_val("rj_count",   32'(rj_cnt),   32'd16);
        check_val("coef_count", 32'(coef_cnt), 32'd512);

        m_n = 255; m_zeros = 0; m_sleep = 1'b0; m_busy = 1'b0; m_overrun = 1'b0;

        // First samples
        send_sample(16'h1234, 1'b1);
        send_sample(16'h0001, 1'b1);
        send_sample(16'hFFFF, 1'b1);

        // Wrap through the circular index
        for (int i = 0; i < 257; i++) send_sample(rand_sample(), 1'b1);

        // Sleep on a long zero run, wake on nonzero
        send_sample(16'h00A5, 1'b1);
        idle(1);
        a0 = alu_cnt;
        for (int i = 0; i < 800; i++) send_sample(16'h0000, 1'b1);
        idle(1);
        check_val("sleep_alu_count", 32'(alu_cnt - a0), 32'd800);
        check_val("sleep_flag",      32'(sleep),        32'd1);
        send_sample(16'h0000, 1'b1);
        send_sample(16'h0005, 1'b1);
        idle(1);
        check_val("wake_alu_count", 32'(alu_cnt - a0), 32'd801);

        // Clear: word coincident with clear_req is dropped
        idle(2);
        in_word    = 16'hBEEF;
        clear_req  = 1'b1;
        word_valid = 1'b1;
        tick();
        clear_req  = 1'b0;
        word_valid = 1'b0;
        m_n = 255; m_zeros = 0; m_sleep = 1'b0; m_overrun = 1'b0;
        check_val("clr_state",   32'(state),   32'd4);
        check_val("clr_inready", 32'(InReady), 32'd0);
        check_val("clr_x_we",    32'(x_we),    32'd1);
        check_val("clr_x_waddr", 32'(x_waddr), 32'd0);
        check_val("clr_wdata",   32'(wdata),   32'd0);
        check_val("clr_alu_en",  32'(alu_en),  32'd0);
        for (int k = 1; k < 256; k++) begin
            in_word    = 16'($urandom) | 16'h0001;
            word_valid = 1'($urandom_range(0, 1));
            tick();
            check_val("clr_sw_x_we",    32'(x_we),    32'd1);
            check_val("clr_sw_x_waddr", 32'(x_waddr), 32'(k));
            check_val("clr_sw_wdata",   32'(wdata),   32'd0);
            check_val("clr_sw_inready", 32'(InReady), 32'd0);
            check_val("clr_sw_alu_en",  32'(alu_en),  32'd0);
        end
        word_valid = 1'b1;
        tick();
        word_valid = 1'b0;
        check_val("clr_done_inready", 32'(InReady), 32'd1);
        check_val("clr_done_state",   32'(state),   32'd3);
        check_val("clr_done_x_we",    32'(x_we),    32'd0);
        check_val("clr_done_n",       32'(n),       32'd255);
        check_val("clr_rj_untouched",   32'(rj_cnt),   32'd16);
        check_val("clr_coef_untouched", 32'(coef_cnt), 32'd512);

        for (int i = 0; i < 5; i++) send_sample(rand_sample() | 16'h0100, 1'b1);

        // Overrun: two samples without alu_done in between, then sticky
        send_sample(16'h1111, 1'b0);
        send_sample(16'h2222, 1'b0);
        check_val("overrun_set", 32'(overrun), 32'd1);
        send_sample(16'h3333, 1'b1);
        send_sample(16'h4444, 1'b1);

        // Clear entry drops overrun; Reset mid-sweep aborts asynchronously
        idle(1);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        check_val("clr2_overrun", 32'(overrun), 32'd0);
        check_val("clr2_state",   32'(state),   32'd4);
        idle(100);
        check_val("clr2_mid_x_we", 32'(x_we), 32'd1);
        #4 Reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        idle(2);
        check_val("midrst_hold_x_we", 32'(x_we), 32'd0);
        Reset = 1'b0;
        tick();
        check_val("rst_resweep_x_we",  32'(x_we),    32'd1);
        check_val("rst_resweep_addr",  32'(x_waddr), 32'd0);
        check_val("alu_without_x_we",  32'(alu_orphan), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
